// File: rtl/lm75_poll_sched_if.sv
// ----------------------------------------------------------------------------
// lm75_poll_sched_if
//   Bundles the two request/response channels of the LM75A poll scheduler:
//   - host port : host_req/rw/ptr/wdata in, host_ack/done/rdata/err out
//   - I2C master: m_valid/addr/rw/ptr/len/wdata out, m_ready/done/nack/rdata in
//   modport master : scheduler view (issues commands to the I2C master,
//                    answers the host)
//   modport slave  : environment view (host logic plus the I2C master)
// ----------------------------------------------------------------------------
interface lm75_poll_sched_if;
   logic        host_req;
   logic        host_rw;
   logic [1:0]  host_ptr;
   logic [15:0] host_wdata;
   logic        host_ack;
   logic        host_done;
   logic [15:0] host_rdata;
   logic        host_err;

   logic        m_valid;
   logic        m_ready;
   logic [6:0]  m_addr;
   logic        m_rw;
   logic [1:0]  m_ptr;
   logic [1:0]  m_len;
   logic [15:0] m_wdata;
   logic        m_done;
   logic        m_nack;
   logic [15:0] m_rdata;

   modport master (
      input  host_req, host_rw, host_ptr, host_wdata,
      output host_ack, host_done, host_rdata, host_err,
      output m_valid, m_addr, m_rw, m_ptr, m_len, m_wdata,
      input  m_ready, m_done, m_nack, m_rdata
   );

   modport slave (
      output host_req, host_rw, host_ptr, host_wdata,
      input  host_ack, host_done, host_rdata, host_err,
      input  m_valid, m_addr, m_rw, m_ptr, m_len, m_wdata,
      output m_ready, m_done, m_nack, m_rdata
   );
endinterface

// File: rtl/lm75_poll_sched.sv
// ----------------------------------------------------------------------------
// lm75_poll_sched
//   Shares one I2C register-access master between a periodic LM75A
//   temperature read and a host register port. Alternating arbitration,
//   bounded NACK retry with back-off, latest good temperature held.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : periodic polling enable
//   bus          : host port and I2C master command/response (master modport)
//   temp         : last successful temperature word
//   temp_valid   : a poll has succeeded since reset
//   poll_err     : last poll failed
//   poll_miss    : pulse, poll period expired with a poll still pending
// ----------------------------------------------------------------------------
module lm75_poll_sched #(
   parameter int unsigned POLL_PERIOD = 50000000,
   parameter int unsigned MAX_RETRY   = 3,
   parameter int unsigned BACKOFF_CYC = 1000,
   parameter logic [6:0]  DEV_ADDR    = 7'h48
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   lm75_poll_sched_if.master         bus,
   output logic [15:0]               temp,
   output logic                      temp_valid,
   output logic                      poll_err,
   output logic                      poll_miss
);

   localparam int unsigned TW = $clog2(POLL_PERIOD + 1);
   localparam int unsigned RW = $clog2(MAX_RETRY + 2);
   localparam int unsigned BW = $clog2(BACKOFF_CYC + 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_BACKOFF, S_RESP} state_t;

   state_t        r_state, w_next;
   logic [TW-1:0] r_timer;
   logic          r_poll_pend;
   logic          r_last_host;
   logic          r_cur_host;
   logic          r_rw;
   logic [1:0]    r_ptr;
   logic [15:0]   r_wdata;
   logic [15:0]   r_rdata;
   logic          r_fail;
   logic [RW-1:0] r_retry;
   logic [BW-1:0] r_bo;
   logic [15:0]   r_temp;
   logic          r_temp_valid;
   logic          r_poll_err;
   logic          r_poll_miss;

   logic w_expire;
   logic w_grant;
   logic w_grant_host;
   logic w_issue;

   assign w_expire = enable && (r_timer == TW'(POLL_PERIOD - 1));
   assign w_issue  = (r_state == S_ISSUE);

   // Command fields are forced to 0 outside ISSUE so every output reads 0
   // while idle and after reset; inside ISSUE they come from latched state.
   assign bus.m_valid = w_issue;
   assign bus.m_addr  = w_issue ? DEV_ADDR : '0;
   assign bus.m_rw    = w_issue & r_rw;
   assign bus.m_ptr   = w_issue ? r_ptr : '0;
   assign bus.m_len   = !w_issue ? 2'd0 : ((r_ptr == 2'd1) ? 2'd1 : 2'd2);
   assign bus.m_wdata = w_issue ? r_wdata : '0;

   assign bus.host_done  = (r_state == S_RESP) && r_cur_host;
   assign bus.host_err   = bus.host_done && r_fail;
   assign bus.host_rdata = (bus.host_done && r_rw && !r_fail) ? r_rdata : '0;

   assign temp       = r_temp;
   assign temp_valid = r_temp_valid;
   assign poll_err   = r_poll_err;
   assign poll_miss  = r_poll_miss;

   always_comb begin
      w_next       = r_state;
      w_grant      = 1'b0;
      w_grant_host = 1'b0;
      bus.host_ack = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_poll_pend || bus.host_req) begin
               w_grant = 1'b1;
               // Host loses only when a poll is also pending and the host had the last grant.
               w_grant_host = bus.host_req && !(r_poll_pend && r_last_host);
               bus.host_ack = w_grant_host;
               w_next       = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bus.m_ready) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (bus.m_done) begin
               if (!bus.m_nack || (r_retry == RW'(MAX_RETRY))) w_next = S_RESP;
               else                                            w_next = S_BACKOFF;
            end
         end
         S_BACKOFF: begin
            if (r_bo == BW'(BACKOFF_CYC - 1)) w_next = S_ISSUE;
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer      <= '0;
         r_poll_pend  <= 1'b0;
         r_last_host  <= 1'b1;
         r_cur_host   <= 1'b0;
         r_rw         <= 1'b0;
         r_ptr        <= '0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_fail       <= 1'b0;
         r_retry      <= '0;
         r_bo         <= '0;
         r_temp       <= '0;
         r_temp_valid <= 1'b0;
         r_poll_err   <= 1'b0;
         r_poll_miss  <= 1'b0;
      end else begin
         r_poll_miss <= 1'b0;

         // A fresh expiry wins over a poll grant in the same cycle, so the
         // new period is not lost; a miss is only reported for a pending
         // poll that is not being consumed right now.
         if (!enable) begin
            r_timer     <= '0;
            r_poll_pend <= 1'b0;
         end else if (w_expire) begin
            r_timer     <= '0;
            r_poll_pend <= 1'b1;
            if (r_poll_pend && !(w_grant && !w_grant_host)) r_poll_miss <= 1'b1;
         end else begin
            r_timer <= r_timer + 1'b1;
            if (w_grant && !w_grant_host) r_poll_pend <= 1'b0;
         end

         if (w_grant) begin
            r_cur_host  <= w_grant_host;
            r_last_host <= w_grant_host;
            r_rw        <= w_grant_host ? bus.host_rw    : 1'b1;
            r_ptr       <= w_grant_host ? bus.host_ptr   : 2'd0;
            r_wdata     <= w_grant_host ? bus.host_wdata : 16'h0000;
            r_retry     <= '0;
         end

         if (r_state == S_WAIT && bus.m_done) begin
            r_rdata <= bus.m_rdata;
            r_fail  <= bus.m_nack;
            r_bo    <= '0;
            if (bus.m_nack && (r_retry != RW'(MAX_RETRY))) r_retry <= r_retry + 1'b1;
         end

         if (r_state == S_BACKOFF) r_bo <= r_bo + 1'b1;

         if (r_state == S_RESP && !r_cur_host) begin
            if (r_fail) begin
               r_poll_err <= 1'b1;
            end else begin
               r_temp       <= r_rdata;
               r_temp_valid <= 1'b1;
               r_poll_err   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_lm75_poll_sched.sv
// ----------------------------------------------------------------------------
// tb_lm75_poll_sched
//   Directed sequence with randomized command/data content against a small
//   behavioural model of the scheduler's externally visible rules. A
//   responder process plays the I2C master and logs every accepted command.
// ----------------------------------------------------------------------------
module tb_lm75_poll_sched;
   localparam int unsigned PP = 100;
   localparam int unsigned MR = 3;
   localparam int unsigned BO = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] temp;
   logic        temp_valid;
   logic        poll_err;
   logic        poll_miss;

   lm75_poll_sched_if bus ();

   lm75_poll_sched #(
      .POLL_PERIOD (PP),
      .MAX_RETRY   (MR),
      .BACKOFF_CYC (BO),
      .DEV_ADDR    (7'h48)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .bus        (bus),
      .temp       (temp),
      .temp_valid (temp_valid),
      .poll_err   (poll_err),
      .poll_miss  (poll_miss)
   );

   always #10 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_assert = 0;
   int n_fail   = 0;

   // responder controls and logs
   bit          ready_block = 1'b0;
   bit          hold_done   = 1'b0;
   bit          busy        = 1'b0;
   bit          cur_nack    = 1'b0;
   int          lat         = 20;
   int          lat_cnt     = 0;
   int          nack_left   = 0;
   logic [15:0] rd_val      = '0;
   logic [27:0] hs_cmd[$];
   int unsigned hs_cyc[$];
   int          ack_cnt  = 0;
   int          done_cnt = 0;
   int          miss_cnt = 0;
   logic [15:0] d_rdata  = '0;
   logic        d_err    = 1'b0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // expected command word {addr, rw, ptr, len, wdata}; wdata is don't-care on reads
   function automatic logic [27:0] cmd(logic rw, logic [1:0] ptr, logic [15:0] wd);
      logic [1:0] len;
      len = (ptr == 2'd1) ? 2'd1 : 2'd2;
      return {7'h48, rw, ptr, len, (rw ? 16'h0000 : wd)};
   endfunction

   function automatic logic [27:0] mask(logic [27:0] c);
      return c[20] ? {c[27:16], 16'h0000} : c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic ticks(int n);
      repeat (n) tick();
   endtask

   task automatic host_start(logic rw, logic [1:0] ptr, logic [15:0] wd, string tag);
      int a0;
      int k;
      a0 = ack_cnt;
      k  = 0;
      bus.host_rw    = rw;
      bus.host_ptr   = ptr;
      bus.host_wdata = wd;
      bus.host_req   = 1'b1;
      while (ack_cnt == a0 && k < 300) begin
         tick();
         k++;
      end
      chk({tag, " ack"}, ack_cnt - a0, 1);
      bus.host_req = 1'b0;
   endtask

   task automatic host_finish(string tag, logic rw, logic [1:0] ptr, logic [15:0] wd,
                              int nacks, logic [15:0] rd, int d0);
      int k;
      int att;
      k = 0;
      while (done_cnt == d0 && k < 600) begin
         tick();
         k++;
      end
      att = (nacks > int'(MR)) ? int'(MR) + 1 : nacks + 1;
      chk({tag, " done"}, done_cnt - d0, 1);
      chk({tag, " attempts"}, hs_cmd.size(), att);
      foreach (hs_cmd[i]) chk({tag, " cmd"}, mask(hs_cmd[i]), cmd(rw, ptr, wd));
      for (int i = 1; i < hs_cyc.size(); i++)
         chk({tag, " backoff"}, (hs_cyc[i] - hs_cyc[i-1]) >= BO, 1);
      chk({tag, " err"}, d_err, (nacks > int'(MR)));
      chk({tag, " rdata"}, d_rdata, (rw && nacks <= int'(MR)) ? rd : 16'h0000);
   endtask

   // I2C master model plus pulse monitors, all evaluated on the falling edge
   initial begin
      bus.m_ready = 1'b0;
      bus.m_done  = 1'b0;
      bus.m_nack  = 1'b0;
      bus.m_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.host_ack === 1'b1) ack_cnt++;
         if (bus.host_done === 1'b1) begin
            done_cnt++;
            d_rdata = bus.host_rdata;
            d_err   = bus.host_err;
         end
         if (poll_miss === 1'b1) miss_cnt++;
         bus.m_done = 1'b0;
         bus.m_nack = 1'b0;
         if (!rst_n) begin
            busy = 1'b0;
         end else if (busy && !hold_done) begin
            if (lat_cnt <= 1) begin
               bus.m_done  = 1'b1;
               bus.m_nack  = cur_nack;
               bus.m_rdata = cur_nack ? 16'($urandom) : rd_val;
               busy = 1'b0;
            end else begin
               lat_cnt--;
            end
         end
         bus.m_ready = !busy && !ready_block;
         if (rst_n && bus.m_valid === 1'b1 && bus.m_ready) begin
            hs_cmd.push_back({bus.m_addr, bus.m_rw, bus.m_ptr, bus.m_len, bus.m_wdata});
            hs_cyc.push_back(cyc);
            busy     = 1'b1;
            lat_cnt  = lat;
            cur_nack = (nack_left > 0);
            if (cur_nack) nack_left--;
         end
      end
   end

   initial begin : main
      int unsigned cE;
      int          k;
      int          d0;
      int          a0;
      int          m0;
      logic [15:0] model_temp;
      logic [15:0] wd;
      logic [15:0] rd;
      logic        rw;
      logic [1:0]  ptr;
      int          nk_tab[8];
      nk_tab = '{0, 3, 4, 1, 0, 2, 4, 0};

      bus.host_req   = 1'b0;
      bus.host_rw    = 1'b0;
      bus.host_ptr   = '0;
      bus.host_wdata = '0;

      // reset values
      #15;
      chk("rst m_valid", bus.m_valid, 0);
      chk("rst m fields", {bus.m_addr, bus.m_rw, bus.m_ptr, bus.m_len, bus.m_wdata}, 0);
      chk("rst host outs", {bus.host_ack, bus.host_done, bus.host_err, bus.host_rdata}, 0);
      chk("rst status", {temp, temp_valid, poll_err, poll_miss}, 0);
      ticks(2);
      rst_n = 1'b1;
      ticks(2);

      // first periodic poll
      lat = 20; rd_val = 16'h1900; nack_left = 0;
      hs_cmd.delete(); hs_cyc.delete();
      enable = 1'b1;
      cE = cyc;
      k = 0;
      while (temp_valid !== 1'b1 && k < 300) begin tick(); k++; end
      chk("poll1 count", hs_cmd.size(), 1);
      if (hs_cmd.size() > 0) begin
         chk("poll1 cmd", hs_cmd[0], cmd(1'b1, 2'd0, 16'h0000));
         chk("poll1 time", (hs_cyc[0] - cE >= PP) && (hs_cyc[0] - cE <= PP + 2), 1);
      end
      chk("poll1 temp", temp, 16'h1900);
      chk("poll1 valid", {temp_valid, poll_err}, 2'b10);
      enable = 1'b0;
      model_temp = 16'h1900;
      ticks(2);

      // host config write
      hs_cmd.delete(); hs_cyc.delete();
      d0 = done_cnt; rd = 16'($urandom); rd_val = rd; nack_left = 0;
      host_start(1'b0, 2'd1, 16'h0002, "cfg wr");
      host_finish("cfg wr", 1'b0, 2'd1, 16'h0002, 0, rd, d0);

      // random host transactions, including retry exhaustion and last-try success
      for (int i = 0; i < 8; i++) begin
         rw = 1'($urandom); ptr = 2'($urandom); wd = 16'($urandom); rd = 16'($urandom);
         hs_cmd.delete(); hs_cyc.delete();
         rd_val = rd; nack_left = nk_tab[i]; lat = int'($urandom_range(2, 12));
         d0 = done_cnt;
         host_start(rw, ptr, wd, "rand host");
         host_finish("rand host", rw, ptr, wd, nk_tab[i], rd, d0);
         ticks(int'($urandom_range(0, 3)));
      end
      chk("temp after host", temp, model_temp);

      // master stalls acceptance while host_req toggles
      hs_cmd.delete(); hs_cyc.delete();
      lat = 10; nack_left = 0; ready_block = 1'b1;
      wd = 16'($urandom); d0 = done_cnt; a0 = ack_cnt;
      host_start(1'b0, 2'd2, wd, "stall");
      for (int i = 0; i < 50; i++) begin
         chk("stall hold", {bus.m_valid, bus.m_addr, bus.m_rw, bus.m_ptr, bus.m_len, bus.m_wdata},
             {1'b1, cmd(1'b0, 2'd2, wd)});
         bus.host_req   = 1'(i % 2);
         bus.host_rw    = 1'($urandom);
         bus.host_ptr   = 2'($urandom);
         bus.host_wdata = 16'($urandom);
         tick();
      end
      bus.host_req = 1'b0;
      chk("stall one grant", ack_cnt - a0, 1);
      ready_block = 1'b0;
      host_finish("stall", 1'b0, 2'd2, wd, 0, rd_val, d0);

      // alternation: host, then pending poll, then waiting host
      hs_cmd.delete(); hs_cyc.delete();
      lat = 10; nack_left = 0; rd_val = 16'($urandom); ready_block = 1'b1;
      d0 = done_cnt;
      enable = 1'b1;
      host_start(1'b1, 2'd3, 16'h0000, "alt F");
      ticks(110);
      wd = 16'($urandom);
      ready_block = 1'b0;
      host_start(1'b0, 2'd2, wd, "alt G");
      k = 0;
      while (done_cnt < d0 + 2 && k < 300) begin tick(); k++; end
      enable = 1'b0;
      chk("alt count", hs_cmd.size(), 3);
      if (hs_cmd.size() >= 3) begin
         chk("alt order0", mask(hs_cmd[0]), cmd(1'b1, 2'd3, 16'h0000));
         chk("alt order1", hs_cmd[1], cmd(1'b1, 2'd0, 16'h0000));
         chk("alt order2", mask(hs_cmd[2]), cmd(1'b0, 2'd2, wd));
      end
      chk("alt G result", {d_err, d_rdata}, 17'h0);
      model_temp = rd_val;
      chk("alt temp", temp, model_temp);
      ticks(2);

      // poll NACKed on every attempt, then a good poll
      hs_cmd.delete(); hs_cyc.delete();
      lat = 5; nack_left = 100;
      enable = 1'b1;
      k = 0;
      while (poll_err !== 1'b1 && k < 400) begin tick(); k++; end
      enable = 1'b0;
      chk("nack attempts", hs_cmd.size(), MR + 1);
      for (int i = 1; i < hs_cyc.size(); i++)
         chk("nack backoff", (hs_cyc[i] - hs_cyc[i-1]) >= BO, 1);
      chk("nack poll_err", poll_err, 1);
      chk("nack temp kept", {temp, temp_valid}, {model_temp, 1'b1});
      hs_cmd.delete(); hs_cyc.delete();
      nack_left = 0; rd_val = 16'($urandom);
      ticks(2);
      enable = 1'b1;
      k = 0;
      while (poll_err !== 1'b0 && k < 300) begin tick(); k++; end
      enable = 1'b0;
      model_temp = rd_val;
      chk("recover poll_err", poll_err, 0);
      chk("recover temp", temp, model_temp);
      chk("recover count", hs_cmd.size(), 1);
      ticks(2);

      // master stall across two expiries
      hs_cmd.delete(); hs_cyc.delete();
      lat = 5; rd_val = 16'($urandom); hold_done = 1'b1;
      m0 = miss_cnt;
      enable = 1'b1;
      ticks(350);
      chk("miss stalled polls", hs_cmd.size(), 1);
      chk("miss pulses", miss_cnt - m0, 1);
      hold_done = 1'b0;
      ticks(40);
      enable = 1'b0;
      chk("miss polls after", hs_cmd.size(), 2);
      chk("miss pulses after", miss_cnt - m0, 1);
      model_temp = rd_val;
      chk("miss temp", temp, model_temp);
      ticks(2);

      // asynchronous reset in WAIT
      hs_cmd.delete(); hs_cyc.delete();
      hold_done = 1'b1;
      host_start(1'b1, 2'd0, 16'h0000, "rstwait");
      k = 0;
      while (hs_cmd.size() == 0 && k < 50) begin tick(); k++; end
      chk("rstwait issued", hs_cmd.size(), 1);
      ticks(3);
      rst_n = 1'b0;
      #1;
      chk("rstwait m", {bus.m_valid, bus.m_addr, bus.m_rw, bus.m_ptr, bus.m_len, bus.m_wdata}, 0);
      chk("rstwait host", {bus.host_ack, bus.host_done, bus.host_err, bus.host_rdata}, 0);
      chk("rstwait status", {temp, temp_valid, poll_err, poll_miss}, 0);
      tick();
      hold_done = 1'b0;
      chk("rstwait held", {bus.m_valid, bus.host_done, temp_valid}, 0);
      tick();
      rst_n = 1'b1;
      ticks(5);
      chk("rstwait idle", {bus.m_valid, bus.host_done, temp_valid}, 0);

      // contended grant right after reset goes to the poll
      hs_cmd.delete(); hs_cyc.delete();
      lat = 5; nack_left = 0; rd_val = 16'($urandom);
      d0 = done_cnt;
      enable = 1'b1;
      ticks(PP);
      wd = 16'($urandom);
      host_start(1'b0, 2'd3, wd, "contend");
      k = 0;
      while (done_cnt == d0 && k < 200) begin tick(); k++; end
      enable = 1'b0;
      chk("contend count", hs_cmd.size(), 2);
      if (hs_cmd.size() >= 2) begin
         chk("contend first poll", hs_cmd[0], cmd(1'b1, 2'd0, 16'h0000));
         chk("contend then host", mask(hs_cmd[1]), cmd(1'b0, 2'd3, wd));
      end
      chk("contend temp", {temp, temp_valid}, {rd_val, 1'b1});
      chk("contend host result", {d_err, d_rdata}, 17'h0);
      ticks(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
